// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator sequencer: FSM state
// encoding, ALU operator codes, error codes and display-select values.
package calc_pkg;

  localparam int NUM_W_DEF   = 14;
  localparam int RES_W_DEF   = 28;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_A_CAP = 3'd1,
    S_OP    = 3'd2,
    S_B     = 3'd3,
    S_B_CAP = 3'd4,
    S_EXEC  = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ALU     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CHAIN   = 2'd3;

  localparam logic [1:0] SEL_LIVE   = 2'd0;
  localparam logic [1:0] SEL_A      = 2'd1;
  localparam logic [1:0] SEL_RESULT = 2'd2;
  localparam logic [1:0] SEL_ERROR  = 2'd3;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful for a one-hot key vector; callers qualify with is_onehot4.
  function automatic logic [1:0] op_from_keys(input logic [3:0] k);
    logic [1:0] code;
    code = OP_ADD;
    case (k)
      4'b0010: code = OP_SUB;
      4'b0100: code = OP_MUL;
      4'b1000: code = OP_DIV;
      default: code = OP_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/calc_sequencer_rise_detect.sv
// Registered rising-edge detector: the rise output is high for one cycle, one
// clock after a bit of the input level goes from 0 to 1.
module rise_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_level,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_prev;
  logic [W-1:0] r_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
      r_rise <= '0;
    end else begin
      r_prev <= i_level;
      r_rise <= i_level & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator controller: captures operand A, operator and operand B,
// runs the external ALU over a start/done handshake and drives the display.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int NUM_W          = NUM_W_DEF,
  parameter int RES_W          = RES_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  input  logic             clear,
  input  logic [3:0]       op_keys,
  input  logic [NUM_W-1:0] num_in,
  output logic [NUM_W-1:0] alu_a,
  output logic [NUM_W-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_start,
  output logic             alu_abort,
  input  logic [RES_W-1:0] alu_result,
  input  logic             alu_done,
  input  logic             alu_err,
  output logic [RES_W-1:0] disp_value,
  output logic [1:0]       disp_sel,
  output logic [1:0]       err_code,
  output logic             busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_enter_rise;
  logic             w_clear_rise;
  logic [3:0]       w_op_rise;
  logic [3:0]       r_op_level;
  logic             w_op_valid;
  logic [1:0]       w_op_code;
  logic             w_timeout;
  logic             w_res_fits;
  logic [CNT_W-1:0] r_cnt;
  logic [NUM_W-1:0] r_a;
  logic [NUM_W-1:0] r_b;
  logic [1:0]       r_op;
  logic [RES_W-1:0] r_result;
  logic [RES_W-1:0] r_disp_value;
  logic [1:0]       r_disp_sel;
  logic [1:0]       r_err_code;

  rise_detect #(.W(1)) u_enter_rise (
    .clk     (clk),
    .reset   (reset),
    .i_level (enter),
    .o_rise  (w_enter_rise)
  );

  rise_detect #(.W(1)) u_clear_rise (
    .clk     (clk),
    .reset   (reset),
    .i_level (clear),
    .o_rise  (w_clear_rise)
  );

  rise_detect #(.W(4)) u_op_rise (
    .clk     (clk),
    .reset   (reset),
    .i_level (op_keys),
    .o_rise  (w_op_rise)
  );

  // Level copy aligned with the op rise output, so the one-hot test judges the
  // same key vector that produced the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_level <= '0;
    end else begin
      r_op_level <= op_keys;
    end
  end

  assign w_op_valid = (|w_op_rise) && is_onehot4(r_op_level);
  assign w_op_code  = op_from_keys(r_op_level);
  assign w_timeout  = (r_cnt == CNT_LAST);
  assign w_res_fits = ~|r_result[RES_W-1:NUM_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_clear_rise) begin
      w_state_next = S_A;
    end else begin
      case (r_state)
        S_A:     if (w_enter_rise) w_state_next = S_A_CAP;
        S_A_CAP: w_state_next = S_OP;
        S_OP:    if (w_op_valid) w_state_next = S_B;
        S_B:     if (w_enter_rise) w_state_next = S_B_CAP;
        S_B_CAP: w_state_next = S_EXEC;
        S_EXEC: begin
          if (alu_done) begin
            w_state_next = alu_err ? S_ERR : S_DONE;
          end else if (w_timeout) begin
            w_state_next = S_ERR;
          end
        end
        S_DONE: begin
          if (w_op_valid) begin
            w_state_next = w_res_fits ? S_B : S_ERR;
          end else if (w_enter_rise) begin
            w_state_next = S_A_CAP;
          end
        end
        S_ERR:   w_state_next = S_ERR;
        default: w_state_next = S_A;
      endcase
    end
  end

  // Start and abort are combinational so the ALU sees them in the same cycle
  // the decision is made; reset suppresses both since the ALU resets too.
  always_comb begin
    busy      = 1'b0;
    alu_start = 1'b0;
    alu_abort = 1'b0;
    if (!reset && r_state == S_EXEC) begin
      busy      = 1'b1;
      alu_start = (r_cnt == '0);
      alu_abort = w_clear_rise || (!alu_done && w_timeout);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= OP_ADD;
      r_result     <= '0;
      r_disp_value <= '0;
      r_disp_sel   <= SEL_LIVE;
      r_err_code   <= ERR_NONE;
      r_cnt        <= '0;
    end else if (w_clear_rise) begin
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_disp_value <= '0;
      r_disp_sel   <= SEL_LIVE;
      r_err_code   <= ERR_NONE;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_A_CAP: begin
          r_a        <= num_in;
          r_disp_sel <= SEL_A;
        end
        S_OP: begin
          if (w_op_valid) begin
            r_op       <= w_op_code;
            r_disp_sel <= SEL_LIVE;
          end
        end
        S_B: begin
          if (w_op_valid) r_op <= w_op_code;
        end
        S_B_CAP: begin
          r_b   <= num_in;
          r_cnt <= '0;
        end
        S_EXEC: begin
          if (alu_done) begin
            if (alu_err) begin
              r_err_code <= ERR_ALU;
              r_disp_sel <= SEL_ERROR;
            end else begin
              r_result     <= alu_result;
              r_disp_value <= alu_result;
              r_disp_sel   <= SEL_RESULT;
            end
          end else if (w_timeout) begin
            r_err_code <= ERR_TIMEOUT;
            r_disp_sel <= SEL_ERROR;
          end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (w_op_valid) begin
            if (w_res_fits) begin
              r_a        <= r_result[NUM_W-1:0];
              r_op       <= w_op_code;
              r_disp_sel <= SEL_LIVE;
            end else begin
              r_err_code <= ERR_CHAIN;
              r_disp_sel <= SEL_ERROR;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign disp_value = r_disp_value;
  assign disp_sel   = r_disp_sel;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed and randomized bench for calc_sequencer; the bench plays the keypad
// and the ALU and predicts outputs from a calculator-level model.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enter;
  logic        clear;
  logic [3:0]  op_keys;
  logic [13:0] num_in;
  logic [13:0] alu_a;
  logic [13:0] alu_b;
  logic [1:0]  alu_op;
  logic        alu_start;
  logic        alu_abort;
  logic [27:0] alu_result;
  logic        alu_done;
  logic        alu_err;
  logic [27:0] disp_value;
  logic [1:0]  disp_sel;
  logic [1:0]  err_code;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Calculator-level model of what the user should see.
  logic [13:0] m_a, m_b;
  logic [1:0]  m_op;
  logic [27:0] m_disp;
  logic [1:0]  m_sel, m_err;

  calc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .enter      (enter),
    .clear      (clear),
    .op_keys    (op_keys),
    .num_in     (num_in),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_abort  (alu_abort),
    .alu_result (alu_result),
    .alu_done   (alu_done),
    .alu_err    (alu_err),
    .disp_value (disp_value),
    .disp_sel   (disp_sel),
    .err_code   (err_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] alu_fn(input logic [13:0] a, input logic [13:0] b,
                                         input logic [1:0] op);
    logic [27:0] xa, xb, r;
    xa = 28'(a);
    xb = 28'(b);
    case (op)
      2'd0:    r = xa + xb;
      2'd1:    r = xa - xb;
      2'd2:    r = xa * xb;
      default: r = (xb == 28'd0) ? 28'd0 : xa / xb;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".alu_a"},      32'(alu_a),      32'(m_a));
    chk({tag, ".alu_b"},      32'(alu_b),      32'(m_b));
    chk({tag, ".alu_op"},     32'(alu_op),     32'(m_op));
    chk({tag, ".disp_value"}, 32'(disp_value), 32'(m_disp));
    chk({tag, ".disp_sel"},   32'(disp_sel),   32'(m_sel));
    chk({tag, ".err_code"},   32'(err_code),   32'(m_err));
  endtask

  task automatic model_clear();
    m_a = '0; m_b = '0; m_disp = '0; m_sel = 2'd0; m_err = 2'd0;
  endtask

  // Enter press that is expected to capture operand A two cycles after the edge.
  task automatic enter_a(input logic [13:0] v);
    num_in = v; enter = 1'b1;
    step(); enter = 1'b0;
    step(); step();
    m_a = v; m_sel = 2'd1;
    check_outputs("enter_a");
  endtask

  // Enter press with no state effect expected.
  task automatic enter_ignored(input logic [13:0] v, input string tag);
    num_in = v; enter = 1'b1;
    step(); enter = 1'b0;
    step(); step(); step();
    check_outputs(tag);
  endtask

  task automatic press_op(input logic [3:0] keys);
    op_keys = keys;
    step(); op_keys = 4'd0;
    step(); step();
  endtask

  task automatic press_clear();
    clear = 1'b1;
    step(); clear = 1'b0;
    step();
    model_clear();
    check_outputs("clear");
    chk("clear.busy", 32'(busy), 32'd0);
  endtask

  // Enter operand B and look for the start pulse; leaves us in EXEC cycle 1.
  task automatic enter_b(input logic [13:0] v, input bit expect_start);
    int lat;
    lat = 0;
    num_in = v; enter = 1'b1;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      step();
      if (i == 1) enter = 1'b0;
      if (alu_start === 1'b1) lat = i;
    end
    if (expect_start) begin
      m_b = v;
      chk("start_latency", 32'(lat), 32'd3);
      chk("exec.busy", 32'(busy), 32'd1);
      check_outputs("exec_entry");
    end else begin
      chk("no_start", 32'(lat), 32'd0);
      check_outputs("b_ignored");
    end
  endtask

  // Act as the ALU: answer lat cycles after start with the model's result.
  task automatic finish_exec(input int lat, input bit err_in);
    logic [27:0] res;
    res = alu_fn(m_a, m_b, m_op);
    for (int k = 1; k < lat; k++) begin
      step();
      chk("start_once", 32'(alu_start), 32'd0);
      chk("hold_a", 32'(alu_a), 32'(m_a));
    end
    alu_done = 1'b1; alu_err = err_in; alu_result = res;
    step();
    alu_done = 1'b0; alu_err = 1'b0; alu_result = '0;
    if (err_in) begin
      m_err = 2'd1; m_sel = 2'd3;
    end else begin
      m_disp = res; m_sel = 2'd2;
    end
    chk("done.busy", 32'(busy), 32'd0);
    check_outputs("exec_done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] a, b;
    logic [1:0]  op;
    logic [3:0]  keys;

    reset = 1'b1; enter = 1'b0; clear = 1'b0; op_keys = 4'd0; num_in = '0;
    alu_result = '0; alu_done = 1'b0; alu_err = 1'b0;
    model_clear(); m_op = 2'd0; m_b = '0;
    repeat (3) step();
    check_outputs("reset");
    chk("reset.busy",  32'(busy),      32'd0);
    chk("reset.start", 32'(alu_start), 32'd0);
    chk("reset.abort", 32'(alu_abort), 32'd0);
    reset = 1'b0;
    step();

    // Basic add 12 + 34
    enter_a(14'd12);
    press_op(4'b0001); m_op = 2'd0; m_sel = 2'd0;
    check_outputs("op_add");
    enter_b(14'd34, 1'b1);
    finish_exec(5, 1'b0);
    chk("add.result", 32'(disp_value), 32'd46);

    // Chain 46 * 100, then 4600 + 15400 = 20000 which cannot chain
    press_op(4'b0100); m_a = m_disp[13:0]; m_op = 2'd2; m_sel = 2'd0;
    check_outputs("chain_mul");
    enter_b(14'd100, 1'b1);
    finish_exec(3, 1'b0);
    press_op(4'b0001); m_a = m_disp[13:0]; m_op = 2'd0; m_sel = 2'd0;
    check_outputs("chain_add");
    enter_b(14'd15400, 1'b1);
    finish_exec(6, 1'b0);
    press_op(4'b0001); m_err = 2'd3; m_sel = 2'd3;
    check_outputs("chain_overflow");
    press_clear();

    // Divide by zero; error state ignores enter and operators
    enter_a(14'd7);
    press_op(4'b1000); m_op = 2'd3; m_sel = 2'd0;
    enter_b(14'd0, 1'b1);
    finish_exec(4, 1'b1);
    enter_b(14'd123, 1'b0);
    press_op(4'b0001);
    check_outputs("err_op_ignored");
    press_clear();

    // Timeout: ALU never answers
    enter_a(14'd5);
    press_op(4'b0001); m_op = 2'd0; m_sel = 2'd0;
    enter_b(14'd6, 1'b1);
    for (int k = 2; k <= 64; k++) begin
      step();
      chk("tmo.abort", 32'(alu_abort), (k == 64) ? 32'd1 : 32'd0);
      chk("tmo.busy", 32'(busy), 32'd1);
    end
    step();
    m_err = 2'd2; m_sel = 2'd3;
    chk("tmo.abort_end", 32'(alu_abort), 32'd0);
    chk("tmo.busy_end", 32'(busy), 32'd0);
    check_outputs("timeout");
    press_clear();

    // Clear in EXEC together with alu_done
    enter_a(14'd3);
    press_op(4'b0001); m_op = 2'd0; m_sel = 2'd0;
    enter_b(14'd4, 1'b1);
    step(); clear = 1'b1;
    step();
    chk("clr_exec.abort", 32'(alu_abort), 32'd1);
    clear = 1'b0; alu_done = 1'b1; alu_result = 28'd7;
    step();
    alu_done = 1'b0; alu_result = '0;
    model_clear();
    chk("clr_exec.abort_end", 32'(alu_abort), 32'd0);
    chk("clr_exec.busy", 32'(busy), 32'd0);
    check_outputs("clr_exec");

    // Multi-hot ignored, enter ignored in operator wait, op beats enter
    enter_a(14'd9);
    press_op(4'b0011);
    check_outputs("multihot");
    enter_ignored(14'd777, "enter_in_op");
    op_keys = 4'b0010; enter = 1'b1; num_in = 14'd555;
    step(); op_keys = 4'd0; enter = 1'b0;
    step(); step();
    m_op = 2'd1; m_sel = 2'd0;
    check_outputs("op_and_enter");
    op_keys = 4'b1000;
    step(); step(); step();
    m_op = 2'd3;
    check_outputs("op_replace");
    enter_b(14'd5, 1'b1);
    finish_exec(3, 1'b0);
    repeat (4) step();
    check_outputs("held_op_no_repeat");
    op_keys = 4'd0;
    step();

    // Randomized calculations with one chaining attempt each
    for (int it = 0; it < 8; it++) begin
      press_clear();
      a  = 14'($urandom_range(0, 16383));
      op = 2'($urandom_range(0, 3));
      b  = (op == 2'd3) ? 14'($urandom_range(1, 16383)) : 14'($urandom_range(0, 16383));
      enter_a(a);
      keys = 4'b0001 << op;
      press_op(keys); m_op = op; m_sel = 2'd0;
      check_outputs("rnd_op");
      enter_b(b, 1'b1);
      finish_exec(int'($urandom_range(2, 30)), 1'b0);
      op   = 2'($urandom_range(0, 3));
      keys = 4'b0001 << op;
      press_op(keys);
      if (m_disp < 28'd16384) begin
        m_a = m_disp[13:0]; m_op = op; m_sel = 2'd0;
        check_outputs("rnd_chain");
        b = (op == 2'd3) ? 14'($urandom_range(1, 16383)) : 14'($urandom_range(0, 16383));
        enter_b(b, 1'b1);
        finish_exec(int'($urandom_range(2, 30)), 1'b0);
      end else begin
        m_err = 2'd3; m_sel = 2'd3;
        check_outputs("rnd_overflow");
      end
    end

    // Reset in EXEC: no abort, everything back to zero
    press_clear();
    enter_a(14'd11);
    press_op(4'b0001); m_op = 2'd0; m_sel = 2'd0;
    enter_b(14'd2, 1'b1);
    step(); reset = 1'b1;
    #1;
    chk("rst_exec.abort", 32'(alu_abort), 32'd0);
    step();
    model_clear(); m_op = 2'd0;
    check_outputs("rst_exec");
    chk("rst_exec.busy", 32'(busy), 32'd0);
    chk("rst_exec.start", 32'(alu_start), 32'd0);
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
